param_fifo: RTL and testbench

PARAM_FIFO -- requirements
Module: param_fifo

---
 rtl/param_fifo.sv | 112 +++++++++++
 tb/tb_param_fifo.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/param_fifo.sv
// ============================================================================
//  Module   : param_fifo
//  Brief    : Parameterised synchronous FIFO with first-word-fall-through read,
//             occupancy count, threshold flags and sticky overflow/underflow.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module param_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  flush,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   C_DEPTH   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   C_AF      = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0]   C_AE      = (ADDR_WIDTH+1)'(AE_THRESH);
  localparam logic [ADDR_WIDTH:0]   C_CNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE = ADDR_WIDTH'(1);

  // Threshold ordering must hold or the flags become meaningless.
  generate
    if (!((AE_THRESH >= 0) && (AE_THRESH < AF_THRESH) && (AF_THRESH <= DEPTH))) begin : g_param_check
      $error("param_fifo: require 0 <= AE_THRESH < AF_THRESH <= DEPTH");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q,  count_d;
  logic                  ovf_q,    ovf_d;
  logic                  udf_q,    udf_d;
  logic                  w_full, w_empty, w_wr_acc, w_rd_acc;

  assign w_full   = (count_q == C_DEPTH);
  assign w_empty  = (count_q == '0);
  assign w_wr_acc = wr && !w_full;
  assign w_rd_acc = rd && !w_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (w_wr_acc) wr_ptr_d = wr_ptr_q + C_PTR_ONE;
      if (w_rd_acc) rd_ptr_d = rd_ptr_q + C_PTR_ONE;
      if (w_wr_acc && !w_rd_acc)      count_d = count_q + C_CNT_ONE;
      else if (!w_wr_acc && w_rd_acc) count_d = count_q - C_CNT_ONE;
      if (wr && w_full)  ovf_d = 1'b1;
      if (rd && w_empty) udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is deliberately never cleared; only the pointers are reset.
  always_ff @(posedge clk) begin
    if (!Reset && !flush && w_wr_acc) mem_q[wr_ptr_q] <= w_data;
  end

  assign r_data       = mem_q[rd_ptr_q];
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (count_q >= C_AF);
  assign almost_empty = (count_q <= C_AE);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

`default_nettype wire

// File: tb/tb_param_fifo.sv
// ============================================================================
//  Module   : tb_param_fifo
//  Brief    : Directed bench for param_fifo with a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_param_fifo;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       flush = 1'b0;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] w_data = 8'h00;
  logic [7:0] r_data;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  param_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_THRESH(14), .AE_THRESH(2)) dut (
    .clk(clk), .Reset(Reset), .flush(flush), .wr(wr), .rd(rd), .w_data(w_data),
    .r_data(r_data), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit model_valid = 1'b0;
  bit done = 1'b0;
  logic [7:0] mq[$];
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: present inputs, advance the model at the edge.
  task automatic step(input bit i_rst, input bit i_fl, input bit i_wr, input bit i_rd,
                      input logic [7:0] i_d);
    bit mfull, mempty;
    Reset = i_rst; flush = i_fl; wr = i_wr; rd = i_rd; w_data = i_d;
    @(posedge clk);
    if (i_rst || i_fl) begin
      mq.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      mfull  = (mq.size() == 16);
      mempty = (mq.size() == 0);
      if (i_wr && mfull)  m_ovf = 1'b1;
      if (i_rd && mempty) m_udf = 1'b1;
      if (i_rd && !mempty) void'(mq.pop_front());
      if (i_wr && !mfull)  mq.push_back(i_d);
    end
    if (i_rst) model_valid = 1'b1;
    #1;
    Reset = 1'b0; flush = 1'b0; wr = 1'b0; rd = 1'b0;
  endtask

  always @(negedge clk) begin
    if (model_valid && !done) begin
      chk("count",        {27'd0, count},        mq.size());
      chk("empty",        {31'd0, empty},        (mq.size() == 0) ? 1 : 0);
      chk("full",         {31'd0, full},         (mq.size() == 16) ? 1 : 0);
      chk("almost_full",  {31'd0, almost_full},  (mq.size() >= 14) ? 1 : 0);
      chk("almost_empty", {31'd0, almost_empty}, (mq.size() <= 2) ? 1 : 0);
      chk("overflow",     {31'd0, overflow},     {31'd0, m_ovf});
      chk("underflow",    {31'd0, underflow},    {31'd0, m_udf});
      if (mq.size() > 0) chk("r_data", {24'd0, r_data}, {24'd0, mq[0]});
    end
  end

  initial begin
    // Reset state
    step(1, 0, 0, 0, 8'h00);
    chk("rst_count", {27'd0, count}, 0);
    chk("rst_empty", {31'd0, empty}, 1);
    chk("rst_full",  {31'd0, full}, 0);
    chk("rst_ae",    {31'd0, almost_empty}, 1);
    chk("rst_af",    {31'd0, almost_full}, 0);
    chk("rst_flags", {30'd0, overflow, underflow}, 0);

    // Single write falls through
    step(0, 0, 1, 0, 8'hA5);
    chk("wr1_empty", {31'd0, empty}, 0);
    chk("wr1_count", {27'd0, count}, 1);
    chk("wr1_rdata", {24'd0, r_data}, 8'hA5);
    chk("wr1_ae",    {31'd0, almost_empty}, 1);

    // Fill to full, then one rejected write
    step(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 0, 8'(i));
      if (i == 12) chk("af_at13", {31'd0, almost_full}, 0);
      if (i == 13) chk("af_at14", {31'd0, almost_full}, 1);
      if (i == 14) chk("full_at15", {31'd0, full}, 0);
    end
    chk("full_at16", {31'd0, full}, 1);
    step(0, 0, 1, 0, 8'hFF);
    chk("ovf_set",     {31'd0, overflow}, 1);
    chk("ovf_count",   {27'd0, count}, 16);
    chk("ovf_rdata",   {24'd0, r_data}, 8'h00);

    // Write+read while full: only the read goes through
    step(0, 0, 1, 1, 8'h77);
    chk("fwr_count",   {27'd0, count}, 15);
    chk("fwr_rdata",   {24'd0, r_data}, 8'h01);
    chk("fwr_ovf",     {31'd0, overflow}, 1);
    for (int i = 1; i < 16; i++) begin
      chk("drain_data", {24'd0, r_data}, i);
      step(0, 0, 0, 1, 8'h00);
    end
    chk("drain_empty", {31'd0, empty}, 1);

    // Underflow is sticky across a subsequent write
    step(1, 0, 0, 0, 8'h00);
    step(0, 0, 0, 1, 8'h00);
    chk("udf_set",   {31'd0, underflow}, 1);
    chk("udf_count", {27'd0, count}, 0);
    chk("udf_empty", {31'd0, empty}, 1);
    step(0, 0, 1, 0, 8'h3C);
    chk("udf_hold",  {31'd0, underflow}, 1);
    chk("udf_rdata", {24'd0, r_data}, 8'h3C);
    step(0, 0, 1, 1, 8'h3D);
    chk("ew_count", {27'd0, count}, 1);
    chk("ew_rdata", {24'd0, r_data}, 8'h3D);

    // Interleaved traffic across two pointer wraps
    step(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 40; i++)
      step(0, 0, 1, (i >= 1) && (i % 5 != 0), 8'(8'h10 + i));
    chk("il_count", {27'd0, count}, 8);
    chk("il_rdata", {24'd0, r_data}, 8'h30);
    chk("il_flags", {30'd0, overflow, underflow}, 0);
    while (mq.size() > 0) step(0, 0, 0, 1, 8'h00);

    // Flush beats coincident write/read and clears sticky flags
    step(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 17; i++) step(0, 0, 1, 0, 8'(8'h40 + i));
    for (int i = 0; i < 11; i++) step(0, 0, 0, 1, 8'h00);
    chk("pre_fl_count", {27'd0, count}, 5);
    chk("pre_fl_ovf",   {31'd0, overflow}, 1);
    step(0, 1, 1, 1, 8'hEE);
    chk("fl_count", {27'd0, count}, 0);
    chk("fl_empty", {31'd0, empty}, 1);
    chk("fl_flags", {30'd0, overflow, underflow}, 0);
    step(0, 0, 1, 0, 8'h5A);
    chk("post_fl_rdata", {24'd0, r_data}, 8'h5A);

    // Reset mid-operation wins over a write
    step(0, 0, 1, 0, 8'h5B);
    step(1, 1, 1, 1, 8'h5C);
    chk("midrst_count", {27'd0, count}, 0);
    chk("midrst_empty", {31'd0, empty}, 1);

    @(negedge clk);
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
